// File: rtl/iter_div_unit_if.sv
// Handshake/data bundle between the issue side and the iterative divider.
//   in_valid/in_ready  : operand handshake (op, src1, src2)
//   out_valid/out_ready: result handshake (result)
// Modports: master = issuing pipeline stage, slave = divider.
interface iter_div_unit_if #(
  parameter int unsigned DATA_LEN = 32
);
  logic                in_valid;
  logic                in_ready;
  logic [1:0]          op;
  logic [DATA_LEN-1:0] src1;
  logic [DATA_LEN-1:0] src2;
  logic                out_valid;
  logic                out_ready;
  logic [DATA_LEN-1:0] result;

  modport master (
    output in_valid, op, src1, src2, out_ready,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  in_valid, op, src1, src2, out_ready,
    output in_ready, out_valid, result
  );
endinterface

// File: rtl/iter_div_unit.sv
// Iterative radix-2 restoring divider for RISC-V DIV/DIVU/REM/REMU.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   flush      : kill in-flight operation, return to IDLE
//   busy       : state != IDLE
//   bus        : iter_div_unit_if.slave (op/src1/src2 in, result out, valid/ready)
// op: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
// Latency: DATA_LEN shift/subtract cycles plus one sign-fix cycle into DONE.
// Optional macro DIV_EARLY_OUT_EN: divide-by-zero and signed overflow skip
// CALC and go straight to DONE one cycle after accept.
module iter_div_unit #(
  parameter int unsigned DATA_LEN = 32,
  parameter int unsigned CNT_LEN  = $clog2(DATA_LEN) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  output logic             busy,
  iter_div_unit_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e              state_q, state_d;
  logic [1:0]          op_q, op_d;
  logic                dvd_neg_q, dvd_neg_d;  // dividend negative (signed ops)
  logic                q_neg_q, q_neg_d;      // operand signs differ (signed ops)
  logic                div0_q, div0_d;
  logic                ovf_q, ovf_d;
  logic [DATA_LEN-1:0] dvd_q, dvd_d;          // dividend, quotient shifts in at LSB
  logic [DATA_LEN-1:0] dvs_q, dvs_d;
  logic [DATA_LEN-1:0] rem_q, rem_d;
  logic [CNT_LEN-1:0]  cnt_q, cnt_d;
  logic [DATA_LEN-1:0] result_q, result_d;

  // Per-cycle datapath and accept-time decode
  logic [DATA_LEN:0]   rem_sh;
  logic [DATA_LEN-1:0] rem_sub;
  logic                rem_ge;
  logic [DATA_LEN-1:0] q_fix, r_fix;
  logic                in_signed, in_neg1, in_neg2, in_div0, in_ovf;
  logic [DATA_LEN-1:0] min_neg;

  assign min_neg = {1'b1, {(DATA_LEN-1){1'b0}}};

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.result    = result_q;
  assign busy          = (state_q != IDLE);

  // Next-state and datapath
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    dvd_neg_d = dvd_neg_q;
    q_neg_d   = q_neg_q;
    div0_d    = div0_q;
    ovf_d     = ovf_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    result_d  = result_q;

    // Remainder is always < divisor, so the subtraction fits in DATA_LEN bits.
    rem_sh  = {rem_q, dvd_q[DATA_LEN-1]};
    rem_sub = rem_sh[DATA_LEN-1:0] - dvs_q;
    rem_ge  = (rem_sh >= {1'b0, dvs_q});

    // Sign fix; restoring division by zero naturally leaves |src1| in rem,
    // so the dividend-sign fix recovers the original src1 bit pattern.
    q_fix = (!op_q[0] && q_neg_q)   ? DATA_LEN'(-dvd_q) : dvd_q;
    r_fix = (!op_q[0] && dvd_neg_q) ? DATA_LEN'(-rem_q) : rem_q;
    if (div0_q) begin
      q_fix = '1;
    end else if (ovf_q) begin
      q_fix = min_neg;
      r_fix = '0;
    end

    in_signed = !bus.op[0];
    in_neg1   = in_signed && bus.src1[DATA_LEN-1];
    in_neg2   = in_signed && bus.src2[DATA_LEN-1];
    in_div0   = (bus.src2 == '0);
    in_ovf    = in_signed && (bus.src1 == min_neg) && (bus.src2 == '1);

    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            op_d      = bus.op;
            dvd_neg_d = in_neg1;
            q_neg_d   = in_neg1 ^ in_neg2;
            div0_d    = in_div0;
            ovf_d     = in_ovf;
            // Most-negative value negates to itself: read as unsigned magnitude.
            dvd_d     = in_neg1 ? DATA_LEN'(-bus.src1) : bus.src1;
            dvs_d     = in_neg2 ? DATA_LEN'(-bus.src2) : bus.src2;
            rem_d     = '0;
            cnt_d     = CNT_LEN'(DATA_LEN);
            state_d   = CALC;
`ifdef DIV_EARLY_OUT_EN
            if (in_div0) begin
              result_d = bus.op[1] ? bus.src1 : '1;
              state_d  = DONE;
            end else if (in_ovf) begin
              result_d = bus.op[1] ? '0 : bus.src1;
              state_d  = DONE;
            end
`endif
          end
        end
        CALC: begin
          if (cnt_q != '0) begin
            rem_d = rem_ge ? rem_sub : rem_sh[DATA_LEN-1:0];
            dvd_d = {dvd_q[DATA_LEN-2:0], rem_ge};
            cnt_d = cnt_q - CNT_LEN'(1);
          end else begin
            result_d = op_q[1] ? r_fix : q_fix;
            state_d  = DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      op_q      <= '0;
      dvd_neg_q <= 1'b0;
      q_neg_q   <= 1'b0;
      div0_q    <= 1'b0;
      ovf_q     <= 1'b0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      dvd_neg_q <= dvd_neg_d;
      q_neg_q   <= q_neg_d;
      div0_q    <= div0_d;
      ovf_q     <= ovf_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      rem_q     <= rem_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
    end
  end

endmodule

// File: tb/tb_iter_div_unit.sv
// Self-checking bench for iter_div_unit: directed corner cases plus random
// operations checked against an arithmetic reference of the RISC-V M rules.
module tb_iter_div_unit;
  localparam int unsigned N = 32;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  logic busy;

  int n_checks = 0;
  int n_errors = 0;

  iter_div_unit_if #(.DATA_LEN(N)) bus ();

  iter_div_unit #(.DATA_LEN(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .busy  (busy),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic is_special(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    return (b == 0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // Reference: RISC-V M semantics with plain SV arithmetic.
  function automatic logic [31:0] ref_div(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    if (b == 0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (!o[0]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = a;
        r = 0;
      end else begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end
    end else begin
      q = a / b;
      r = a % b;
    end
    return o[1] ? r : q;
  endfunction

  function automatic int exp_latency(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_EARLY_OUT_EN
    if (is_special(o, a, b)) return 1;
`else
    if (is_special(o, a, b)) return 33;
`endif
    return 33;
  endfunction

  // Issue one op, wait for result, optionally hold out_ready low, then retire.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int hold, input logic chk_lat);
    logic [31:0] exp;
    int lat;
    int bad_hs;
    int bad_hold;
    exp = ref_div(o, a, b);
    @(negedge clk);
    chk({tag, "_rdy"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.op = o;
    bus.src1 = a;
    bus.src2 = b;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    bus.src1 = $urandom;
    bus.src2 = $urandom;
    lat = 0;
    bad_hs = 0;
    while (lat < 100) begin
      @(posedge clk);
      #1 lat++;
      if (bus.out_valid) break;
      if (bus.in_ready || !busy) bad_hs++;
    end
    chk({tag, "_busy"}, 32'(bad_hs), 32'd0);
    chk({tag, "_res"}, bus.result, exp);
    if (chk_lat) chk({tag, "_lat"}, 32'(lat), 32'(exp_latency(o, a, b)));
    bad_hold = 0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      bus.in_valid = i[0];
      bus.op = 2'($urandom);
      @(posedge clk);
      #1;
      if (!bus.out_valid || bus.in_ready || bus.result !== exp) bad_hold++;
    end
    bus.in_valid = 1'b0;
    if (hold > 0) chk({tag, "_hold"}, 32'(bad_hold), 32'd0);
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    if (hold > 0) begin
      chk({tag, "_idle_rdy"}, 32'(bus.in_ready), 32'd1);
      chk({tag, "_idle_vld"}, 32'(bus.out_valid), 32'd0);
    end
  endtask

  logic [31:0] specials [5];

  initial begin
    logic [1:0] o;
    logic [31:0] a, b;
    int bad;
    specials[0] = 32'h0;
    specials[1] = 32'h1;
    specials[2] = 32'hFFFF_FFFF;
    specials[3] = 32'h8000_0000;
    specials[4] = 32'h7FFF_FFFF;

    rst_n = 1'b0;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.op = 2'b00;
    bus.src1 = '0;
    bus.src2 = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_result", bus.result, 32'h0);
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(bus.in_ready), 32'd1);

    // Directed cases
    run_op("divu_100_7", 2'b01, 32'd100, 32'd7, 0, 1'b1);
    chk("divu_ref", ref_div(2'b01, 32'd100, 32'd7), 32'd14);
    run_op("remu_100_7", 2'b11, 32'd100, 32'd7, 0, 1'b1);
    run_op("div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2, 0, 1'b0);
    run_op("rem_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 0, 1'b0);
    run_op("rem_7_m2", 2'b10, 32'd7, 32'hFFFF_FFFE, 0, 1'b0);
    run_op("div_5_0", 2'b00, 32'd5, 32'd0, 0, 1'b1);
    run_op("remu_5_0", 2'b11, 32'd5, 32'd0, 0, 1'b1);
    run_op("div_m5_0", 2'b00, 32'hFFFF_FFFB, 32'd0, 0, 1'b1);
    run_op("rem_m5_0", 2'b10, 32'hFFFF_FFFB, 32'd0, 0, 1'b0);
    run_op("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b1);
    run_op("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
    run_op("divu_ovf", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
    run_op("remu_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
    run_op("bp_div", 2'b00, 32'd1000, 32'hFFFF_FFFD, 5, 1'b1);
    @(negedge clk);
    chk("bp_no_accept", 32'(busy), 32'd0);

    // flush while IDLE with in_valid: must not accept
    @(negedge clk);
    bus.in_valid = 1'b1;
    flush = 1'b1;
    bus.op = 2'b01;
    bus.src1 = 32'd50;
    bus.src2 = 32'd5;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    flush = 1'b0;
    chk("flush_idle_busy", 32'(busy), 32'd0);

    // flush on the 10th CALC cycle
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op = 2'b01;
    bus.src1 = 32'd1234567;
    bus.src2 = 32'd89;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    chk("flush_ready", 32'(bus.in_ready), 32'd1);
    chk("flush_busy", 32'(busy), 32'd0);
    bad = 0;
    repeat (40) begin
      @(posedge clk);
      #1 if (bus.out_valid) bad++;
    end
    chk("flush_no_valid", 32'(bad), 32'd0);
    run_op("post_flush", 2'b01, 32'd9, 32'd3, 0, 1'b1);

    // reset mid-CALC clears result and valid
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op = 2'b00;
    bus.src1 = 32'd77;
    bus.src2 = 32'd5;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (12) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk("midrst_result", bus.result, 32'h0);
    chk("midrst_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_ready", 32'(bus.in_ready), 32'd1);

    // Random ops, operands mixed with corner values
    for (int k = 0; k < 40; k++) begin
      o = 2'($urandom);
      a = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : 32'($urandom);
      case ($urandom_range(0, 3))
        0: b = specials[$urandom_range(0, 4)];
        1: b = 32'($urandom_range(1, 20));
        2: b = 32'($urandom) >> $urandom_range(0, 31);
        default: b = 32'($urandom);
      endcase
      run_op($sformatf("rnd%0d", k), o, a, b, (k % 8 == 7) ? 2 : 0, k[0]);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
